// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Drives all 16 combinations of a 4-input function block in ascending order.
//   Each vector is held for HOLD_CYCLES cycles. The block output f is sampled at
//   the end of each hold window, and the resulting truth table is checked
//   against an expected table that was latched at start.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            begin a sweep (accepted only in IDLE or DONE)
//   expected[15:0]   expected f per index, latched on an accepted start
//   f                output of the downstream function block
//   a, b, c, d       registered drive to the block (idx[3], idx[2], idx[1], idx[0])
//   busy             sweep in progress
//   done             sweep complete, held until the next accepted start or rst
//   pass             valid while done; 1 when no mismatches were seen
//   captured[15:0]   sampled f values, bit i = f at index i
//   mismatch_count   number of mismatching indices (0..16)
//   fail_valid       at least one mismatch this sweep
//   first_fail_idx   lowest mismatching index, meaningful when fail_valid = 1
module truth_table_sweeper #(
  parameter int unsigned HOLD_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] captured,
  output logic [4:0]  mismatch_count,
  output logic        fail_valid,
  output logic [3:0]  first_fail_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] cap_q, cap_d;
  logic [4:0]  mm_q, mm_d;
  logic        fv_q, fv_d;
  logic [3:0]  ffi_q, ffi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic        miss;
  logic [4:0]  mm_inc;

  // f is combinational from the registered idx, so it already reflects
  // the current vector when it is sampled.
  assign miss   = f ^ exp_q[idx_q];
  assign mm_inc = mm_q + {4'd0, miss};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    exp_d   = exp_q;
    cap_d   = cap_q;
    mm_d    = mm_q;
    fv_d    = fv_q;
    ffi_d   = ffi_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          hold_d  = '0;
          exp_d   = expected;
          cap_d   = '0;
          mm_d    = '0;
          fv_d    = 1'b0;
          ffi_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end else begin
          cap_d[idx_q] = f;
          mm_d         = mm_inc;
          if (miss && !fv_q) begin
            fv_d  = 1'b1;
            ffi_d = idx_q;
          end
          if (idx_q == 4'd15) begin
            // idx stays at 15 so a..d remain 1111 while DONE.
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mm_inc == 5'd0);
          end else begin
            idx_d  = idx_q + 4'd1;
            hold_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      mm_q    <= '0;
      fv_q    <= 1'b0;
      ffi_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      mm_q    <= mm_d;
      fv_q    <= fv_d;
      ffi_q   <= ffi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign a              = idx_q[3];
  assign b              = idx_q[2];
  assign c              = idx_q[1];
  assign d              = idx_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign captured       = cap_q;
  assign mismatch_count = mm_q;
  assign fail_valid     = fv_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start1, start2;
  logic [15:0] exp1, exp2;
  logic        fsel;

  logic        a1, b1, c1, d1, busy1, done1, pass1, fv1;
  logic [15:0] cap1;
  logic [4:0]  mm1;
  logic [3:0]  ffi1;
  logic        f1;

  logic        a2, b2, c2, d2, busy2, done2, pass2, fv2;
  logic [15:0] cap2;
  logic [4:0]  mm2;
  logic [3:0]  ffi2;
  logic        f2;

  // Function block models: parity (or stuck-at-0) for dut1, 4-input AND for dut2.
  assign f1 = fsel ? (a1 ^ b1 ^ c1 ^ d1) : 1'b0;
  assign f2 = a2 & b2 & c2 & d2;

  truth_table_sweeper #(.HOLD_CYCLES(5)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected(exp1), .f(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .captured(cap1), .mismatch_count(mm1), .fail_valid(fv1), .first_fail_idx(ffi1)
  );

  truth_table_sweeper #(.HOLD_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .expected(exp2), .f(f2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .pass(pass2),
    .captured(cap2), .mismatch_count(mm2), .fail_valid(fv2), .first_fail_idx(ffi2)
  );

  typedef struct {
    logic [15:0] cap;
    logic [4:0]  mm;
    logic        fv;
    logic [3:0]  ffi;
    logic        pass;
    int unsigned lat;
  } res_t;

  res_t sb[$];
  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference result: fmode 0 = parity, 1 = constant 0, 2 = AND of all inputs.
  function automatic res_t model(input int fmode, input logic [15:0] ex, input int unsigned lat);
    res_t r;
    logic fv;
    r.cap = '0; r.mm = '0; r.fv = 1'b0; r.ffi = '0; r.lat = lat;
    for (int i = 0; i < 16; i++) begin
      case (fmode)
        0:       fv = ^(i[3:0]);
        1:       fv = 1'b0;
        default: fv = (i == 15);
      endcase
      r.cap[i] = fv;
      if (fv != ex[i]) begin
        r.mm = r.mm + 5'd1;
        if (!r.fv) begin
          r.fv  = 1'b1;
          r.ffi = 4'(i);
        end
      end
    end
    r.pass = (r.mm == 5'd0);
    return r;
  endfunction

  task automatic check_result(input string tag, input int unsigned lat, input logic [15:0] cap,
                              input logic [4:0] mm, input logic fv, input logic [3:0] ffi,
                              input logic ps);
    res_t r;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      r = sb.pop_front();
      chk({tag, "_latency"}, 64'(lat), 64'(r.lat));
      chk({tag, "_captured"}, 64'(cap), 64'(r.cap));
      chk({tag, "_mismatch"}, 64'(mm), 64'(r.mm));
      chk({tag, "_fail_valid"}, 64'(fv), 64'(r.fv));
      if (r.fv) chk({tag, "_first_fail"}, 64'(ffi), 64'(r.ffi));
      chk({tag, "_pass"}, 64'(ps), 64'(r.pass));
    end
  endtask

  // mode 1 disturbs the running sweep with an expected change and a stray start.
  task automatic sweep1(input string tag, input int fmode, input logic [15:0] ex, input int mode);
    int unsigned cyc;
    exp1 = ex;
    start1 = 1'b1;
    sb.push_back(model(fmode, ex, 80));
    @(negedge clk);
    start1 = 1'b0;
    cyc = 1;
    chk({tag, "_t0_busy"}, 64'(busy1), 64'd1);
    chk({tag, "_t0_abcd"}, 64'({a1, b1, c1, d1}), 64'd0);
    while (!done1 && cyc < 200) begin
      if (mode == 1 && cyc == 10) exp1 = 16'h0000;
      if (mode == 1 && cyc == 20) start1 = 1'b1;
      if (mode == 1 && cyc == 21) start1 = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start1 = 1'b0;
    if (!done1) chk({tag, "_timeout"}, 64'd0, 64'd1);
    check_result(tag, cyc - 1, cap1, mm1, fv1, ffi1, pass1);
    chk({tag, "_done_busy"}, 64'(busy1), 64'd0);
    chk({tag, "_done_abcd"}, 64'({a1, b1, c1, d1}), 64'hF);
  endtask

  initial begin
    int unsigned cyc;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; exp1 = '0; exp2 = '0; fsel = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_dut1", 64'({a1, b1, c1, d1, busy1, done1, pass1, cap1, mm1, fv1, ffi1}), 64'd0);
    chk("reset_dut2", 64'({a2, b2, c2, d2, busy2, done2, pass2, cap2, mm2, fv2, ffi2}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: parity with matching table
    sweep1("s1", 0, 16'h6996, 0);
    // 2: single mismatch at index 0 (restart from DONE)
    sweep1("s2", 0, 16'h6997, 0);
    // 3: f stuck at 0 against all-ones
    fsel = 1'b0;
    sweep1("s3", 1, 16'hFFFF, 0);
    fsel = 1'b1;
    // 4: stray start and expected change during DRIVE are ignored
    sweep1("s4", 0, 16'h6996, 1);

    // 5: reset mid-sweep, then a clean sweep
    exp1 = 16'h6996;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (32) @(negedge clk);
    chk("s5_busy_before_rst", 64'(busy1), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s5_after_rst", 64'({a1, b1, c1, d1, busy1, done1, pass1, cap1, mm1, fv1, ffi1}), 64'd0);
    @(negedge clk);
    chk("s5_idle_stays", 64'({busy1, done1, a1, b1, c1, d1}), 64'd0);
    sweep1("s5", 0, 16'h6996, 0);

    // 6: HOLD_CYCLES = 1, vectors step every edge
    exp2 = 16'h8000;
    start2 = 1'b1;
    sb.push_back(model(2, 16'h8000, 16));
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 40) begin
      chk($sformatf("s6_abcd_%0d", cyc - 1), 64'({a2, b2, c2, d2}), 64'(cyc - 1));
      @(negedge clk);
      cyc++;
    end
    if (!done2) chk("s6_timeout", 64'd0, 64'd1);
    check_result("s6", cyc - 1, cap2, mm2, fv2, ffi2, pass2);
    chk("s6_done_abcd", 64'({a2, b2, c2, d2}), 64'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage that sits directly upstream of a 4-input combinational function block (inputs a, b, c, d; output f). On a start pulse it:
- drives all 16 input combinations in ascending binary order, holding each for a programmable number of cycles;
- samples f at the end of each hold window into a 16-bit captured truth table;
- compares the result against an expected truth table and reports pass/fail with mismatch statistics.

## Interface
- HOLD_CYCLES, default 5: cycles each input vector is held; legal range 1..255.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; honoured only in IDLE or DONE
- expected  input  16  expected f per index; bit i corresponds to index i; latched on an accepted start
- f  input  1  output of the downstream function block
- a, b, c, d  output  1 each  registered drive to the function block; a = idx[3], b = idx[2], c = idx[1], d = idx[0]
- busy  output  1  sweep in progress
- done  output  1  sweep complete; held until the next accepted start or rst
- pass  output  1  valid while done; 1 when mismatch_count == 0
- captured  output  16  sampled f values, bit i = f at index i
- mismatch_count  output  5  number of indices where captured != expected (0..16)
- fail_valid  output  1  at least one mismatch seen this sweep
- first_fail_idx  output  4  lowest mismatching index; meaningful only when fail_valid = 1

## Operation
- States: IDLE, DRIVE, DONE.
- Reset value of every output and internal register is 0; the FSM resets to IDLE.
- **IDLE / DONE + start:**
  - load idx = 0 and hold counter = 0;
  - latch expected into exp_q;
  - clear captured, mismatch_count, fail_valid, first_fail_idx, done and pass;
  - set busy = 1 and go to DRIVE.
- **DRIVE, hold counter < HOLD_CYCLES-1:** increment the hold counter.
- **DRIVE, hold counter == HOLD_CYCLES-1 (sample edge):**
  - captured[idx] <= f;
  - if f != exp_q[idx]: increment mismatch_count; if fail_valid == 0, set fail_valid = 1 and first_fail_idx = idx;
  - if idx == 15: go to DONE, set busy = 0 and done = 1; pass = 1 only if the final mismatch_count, including this sample, is 0;
  - otherwise: idx <= idx + 1 and hold counter <= 0.
- start in DRIVE is ignored.
- expected changes after an accepted start have no effect on the running sweep.
- idx does not wrap. The sweep ends at 15 and a, b, c, d stay at 1111 in DONE until restart or rst.
- A restart from DONE drives a, b, c, d back to 0000 on the accepting edge.
- mismatch_count is 5 bits so that 16 mismatches are representable without overflow.
- rst has priority over start and over every state. A reset mid-sweep returns all outputs to 0 on the next edge and discards partial results.

## Timing
- Let T0 be the edge where start is accepted.
- After T0: busy = 1 and a, b, c, d = 0000.
- Vector i is driven from edge T0 + i*H to edge T0 + (i+1)*H, where H = HOLD_CYCLES.
- f for vector i is sampled at edge T0 + (i+1)*H. f is combinational from the registered a..d, so with H = 1 the sample uses the value settled within the same cycle.
- Final sample and done = 1 occur at edge T0 + 16*H; busy falls on that same edge.
- captured, mismatch_count and fail_valid update on their sample edge, with no extra latency.
- A start held high continuously restarts the sweep on the edge after done rises; it is not a level-triggered loop inside DRIVE.

## Test plan
1. H = 5, f modelled as a^b^c^d, expected = 16'h6996, start at T0 -> done at T0+80, captured = 16'h6996, mismatch_count = 0, pass = 1, fail_valid = 0.
2. Same as 1 with expected = 16'h6997 -> mismatch_count = 1, fail_valid = 1, first_fail_idx = 0, pass = 0, captured = 16'h6996.
3. f tied 0, expected = 16'hFFFF -> captured = 16'h0000, mismatch_count = 16, first_fail_idx = 0, pass = 0.
4. Run 1, plus a start pulse at T0+20 and expected changed to 16'h0000 at T0+10 -> both ignored; results identical to scenario 1 and done still at T0+80.
5. Run 1, then rst high for one edge at T0+33 -> next edge all outputs 0 and state IDLE. A fresh start then completes a full 80-cycle sweep with pass = 1.
6. HOLD_CYCLES = 1, f = a&b&c&d, expected = 16'h8000 -> a..d step 0000..1111 on consecutive edges, done at T0+16, captured = 16'h8000, pass = 1.
